uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit-side buffer for the UART: host writes bytes in, block dispatches them one at a time to the UART
//  transmitter via a start/busy handshake. Mirror of the receive FIFO path.
//  Single clock (Clk), asynchronous active-low reset (Rst_N); circular buffer plus 4-state dispatch FSM.
// PARAMETERS
//  DATA_BITS   8  width of one character
//  FIFO_DEPTH  4  number of entries; power of two, >= 2
// PORTS
//  Clk            in   1                         system clock, all state on rising edge
//  Rst_N          in   1                         asynchronous active-low reset
//  Tx_Data_In     in   DATA_BITS                 host write data
//  Write_En       in   1                         host write strobe, sampled every edge
//  BIST_Mode      in   1                         1 = ignore writes, hold new dispatches
//  Ovf_Clr        in   1                         clears sticky FIFO_Overflow
//  Tx_Busy        in   1                         transmitter busy (frame in progress)
//  Tx_Start       out  1                         one-cycle start pulse to transmitter
//  Tx_Data        out  DATA_BITS                 character for transmitter, valid with Tx_Start
//  FIFO_Empty     out  1                         Count == 0
//  FIFO_Full      out  1                         Count == FIFO_DEPTH
//  FIFO_Overflow  out  1                         sticky: write dropped while full
//  Count          out  $clog2(FIFO_DEPTH+1)      entries held
// BEHAVIOUR
//  Reset (async assert, sync release): WPtr=RPtr=Count=0, state IDLE, Tx_Start=0, Tx_Data=0,
//   FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0; storage contents don't care.
//  Pointers: $clog2(FIFO_DEPTH) bits, wrap DEPTH-1 -> 0 naturally; Count tracks occupancy separately.
//  Write: Write_En=1 & !BIST_Mode & (!full | pop same edge) -> mem[WPtr]<=Tx_Data_In, WPtr++.
//  Write when full with no pop same edge -> data dropped, pointers unchanged, FIFO_Overflow<=1.
//  Write_En while BIST_Mode=1 -> ignored, no overflow flag.
//  Ovf_Clr=1 clears FIFO_Overflow next edge; simultaneous set and clear -> set wins.
//  Pop happens only on the IDLE->LOAD edge: Tx_Data<=mem[RPtr], RPtr++, Count--.
//  Simultaneous write+pop: Count unchanged; allowed when full (write is accepted).
//   Write into empty FIFO is never popped on the same edge.
//  Flags are registered, derived from next Count, so they are valid the cycle after the causing edge.
//  FSM:
//   IDLE       : !FIFO_Empty & !Tx_Busy & !BIST_Mode -> LOAD (pop, Tx_Start<=1); else stay
//   LOAD       : Tx_Start=1 for exactly this cycle; -> WAIT_BUSY, Tx_Start<=0
//   WAIT_BUSY  : Tx_Busy=1 -> WAIT_DONE; else stay (transmitter not yet accepted)
//   WAIT_DONE  : Tx_Busy=0 -> IDLE; else stay
//  Tx_Data holds the last dispatched character until the next LOAD; never changes mid-frame.
//  BIST_Mode asserted mid-frame: current frame completes normally; FSM then holds in IDLE.
//  Latency: write at edge k into an empty FIFO, IDLE, Tx_Busy=0 -> Tx_Start high from edge k+1 to k+2.
//  Back-to-back: next Tx_Start no earlier than 1 cycle after Tx_Busy falls.
//  Reset mid-frame: Tx_Start drops immediately; queued data is lost.
// TESTING
//  1 Reset, write 0xA5 @k, Tx_Busy model 10 cycles -> Tx_Start 1 cycle @k+1, Tx_Data=0xA5, Empty=1 after pop.
//  2 Hold Tx_Busy=1, write 0x11,0x22,0x33,0x44 -> Full=1, Count=4; 5th write 0x55 -> Overflow=1, 0x55
//    never sent; release busy -> 0x11..0x44 sent in order.
//  3 Overflow set, pulse Ovf_Clr -> Overflow=0 next cycle; Ovf_Clr together with a new overflowing
//    write -> Overflow stays 1.
//  4 Full FIFO, write 0x66 on the IDLE->LOAD edge -> accepted, Count stays 4, Overflow=0; 0x66 sent last.
//  5 Write 20 bytes with random Tx_Busy timing -> all 20 sent in order (pointer wrap), no dup/loss.
//  6 BIST_Mode=1 -> writes ignored, no Tx_Start; assert mid-frame -> frame ends, no next start until clear;
//    Rst_N low mid-frame -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit-side character FIFO for the UART: buffers host writes and hands them one at a
// time to the transmitter through a start/busy handshake.
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                             Clk,
   input  logic                             Rst_N,
   input  logic [DATA_BITS-1:0]             Tx_Data_In,
   input  logic                             Write_En,
   input  logic                             BIST_Mode,
   input  logic                             Ovf_Clr,
   input  logic                             Tx_Busy,
   output logic                             Tx_Start,
   output logic [DATA_BITS-1:0]             Tx_Data,
   output logic                             FIFO_Empty,
   output logic                             FIFO_Full,
   output logic                             FIFO_Overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  Count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t               state;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wptr;
   logic [PTR_W-1:0]     rptr;
   logic                 pop;
   logic                 push;
   logic                 drop;
   logic [CNT_W-1:0]     count_nxt;

   // A pop frees a slot on the same edge, so a write into a full FIFO is still accepted then.
   always_comb begin
      pop       = (state == IDLE) && !FIFO_Empty && !Tx_Busy && !BIST_Mode;
      push      = Write_En && !BIST_Mode && (!FIFO_Full || pop);
      drop      = Write_En && !BIST_Mode && FIFO_Full && !pop;
      count_nxt = Count;
      if (push && !pop)
         count_nxt = Count + CNT_W'(1);
      else if (pop && !push)
         count_nxt = Count - CNT_W'(1);
   end

   always_ff @(posedge Clk) begin
      if (push)
         mem[wptr] <= Tx_Data_In;
   end

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         wptr          <= '0;
         Count         <= '0;
         FIFO_Empty    <= 1'b1;
         FIFO_Full     <= 1'b0;
         FIFO_Overflow <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + PTR_W'(1);
         Count      <= count_nxt;
         FIFO_Empty <= (count_nxt == '0);
         FIFO_Full  <= (count_nxt == CNT_W'(FIFO_DEPTH));
         if (drop)
            FIFO_Overflow <= 1'b1;
         else if (Ovf_Clr)
            FIFO_Overflow <= 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state    <= IDLE;
         rptr     <= '0;
         Tx_Start <= 1'b0;
         Tx_Data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  Tx_Data  <= mem[rptr];
                  rptr     <= rptr + PTR_W'(1);
                  Tx_Start <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               Tx_Start <= 1'b0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (Tx_Busy)
                  state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (!Tx_Busy)
                  state <= IDLE;
            end
            default: begin
               Tx_Start <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference of the FIFO contents plus a randomised
// transmitter busy responder, driven from one stimulus process.
module tb_uart_tx_fifo;

   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = $clog2(FIFO_DEPTH+1);

   logic             Clk = 1'b0;
   logic             Rst_N = 1'b0;
   logic [7:0]       Tx_Data_In = '0;
   logic             Write_En = 1'b0;
   logic             BIST_Mode = 1'b0;
   logic             Ovf_Clr = 1'b0;
   logic             Tx_Busy = 1'b0;
   logic             Tx_Start;
   logic [7:0]       Tx_Data;
   logic             FIFO_Empty;
   logic             FIFO_Full;
   logic             FIFO_Overflow;
   logic [CNT_W-1:0] Count;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] q[$];
   logic       exp_ovf = 1'b0;
   logic [7:0] last_sent = '0;
   int         starts = 0;
   logic       prev_start = 1'b0;
   bit         auto_busy = 1'b0;
   bit         bact = 1'b0;
   int         bdly = 0;
   int         blen = 0;
   int         dly_lo = 0;
   int         dly_hi = 0;
   int         len_lo = 1;
   int         len_hi = 1;

   uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .Clk           (Clk),
      .Rst_N         (Rst_N),
      .Tx_Data_In    (Tx_Data_In),
      .Write_En      (Write_En),
      .BIST_Mode     (BIST_Mode),
      .Ovf_Clr       (Ovf_Clr),
      .Tx_Busy       (Tx_Busy),
      .Tx_Start      (Tx_Start),
      .Tx_Data       (Tx_Data),
      .FIFO_Empty    (FIFO_Empty),
      .FIFO_Full     (FIFO_Full),
      .FIFO_Overflow (FIFO_Overflow),
      .Count         (Count)
   );

   always #5 Clk = ~Clk;

   // One clock: inputs set before the call are taken at the edge; model updated and checked after it.
   task automatic tick();
      logic       wr_req;
      logic       ovclr;
      logic       bist_prev;
      logic       busy_prev;
      logic       drop;
      logic [7:0] wr_dat;
      wr_req    = Write_En && !BIST_Mode;
      wr_dat    = Tx_Data_In;
      ovclr     = Ovf_Clr;
      bist_prev = BIST_Mode;
      busy_prev = Tx_Busy;
      drop      = 1'b0;
      @(posedge Clk);
      #1;
      if (!Rst_N) begin
         q.delete();
         exp_ovf   = 1'b0;
         last_sent = '0;
         bact      = 1'b0;
      end else begin
         if (Tx_Start) begin
            starts++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL start_empty: Tx_Start=1 with Tx_Data=%h, expected no start (model queue empty)", Tx_Data);
            end else begin
               last_sent = q.pop_front();
            end
            checks++;
            if (bist_prev || busy_prev || prev_start) begin
               errors++;
               $display("FAIL start_gate: Tx_Start=1 with bist=%0b busy=%0b prev_start=%0b, expected all 0",
                        bist_prev, busy_prev, prev_start);
            end
            if (auto_busy) begin
               bdly = int'($urandom_range(dly_hi, dly_lo));
               blen = int'($urandom_range(len_hi, len_lo));
               bact = 1'b1;
            end
         end else if (auto_busy && bact) begin
            if (bdly > 0) begin
               bdly--;
            end else if (blen > 0) begin
               Tx_Busy = 1'b1;
               blen--;
            end else begin
               Tx_Busy = 1'b0;
               bact    = 1'b0;
            end
         end
         if (wr_req) begin
            if (q.size() < FIFO_DEPTH) q.push_back(wr_dat);
            else drop = 1'b1;
         end
         if (drop) exp_ovf = 1'b1;
         else if (ovclr) exp_ovf = 1'b0;
      end
      checks++;
      if (Tx_Data !== last_sent) begin
         errors++;
         $display("FAIL tx_data: got %h expected %h", Tx_Data, last_sent);
      end
      checks++;
      if (Count !== CNT_W'(q.size())) begin
         errors++;
         $display("FAIL count: got %0d expected %0d", Count, q.size());
      end
      checks++;
      if (FIFO_Empty !== (q.size() == 0)) begin
         errors++;
         $display("FAIL empty: got %b expected %b", FIFO_Empty, (q.size() == 0));
      end
      checks++;
      if (FIFO_Full !== (q.size() == FIFO_DEPTH)) begin
         errors++;
         $display("FAIL full: got %b expected %b", FIFO_Full, (q.size() == FIFO_DEPTH));
      end
      checks++;
      if (FIFO_Overflow !== exp_ovf) begin
         errors++;
         $display("FAIL overflow: got %b expected %b", FIFO_Overflow, exp_ovf);
      end
      prev_start = Tx_Start;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q.size() != 0 || bact) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (q.size() != 0 || bact) begin
         errors++;
         $display("FAIL drain_timeout: %0d bytes still queued after %0d cycles, expected 0", q.size(), n);
      end
      repeat (3) tick();
   endtask

   task automatic wait_starts(input int target, input int budget);
      int n;
      n = 0;
      while (starts < target && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (starts < target) begin
         errors++;
         $display("FAIL start_timeout: got %0d starts expected %0d", starts, target);
      end
   endtask

   task automatic test_reset();
      Rst_N = 1'b0;
      repeat (2) tick();
      checks++;
      if ({Tx_Start, Tx_Data, FIFO_Empty, FIFO_Full, FIFO_Overflow, Count} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_values: got start=%b data=%h empty=%b full=%b ovf=%b count=%0d expected 0 00 1 0 0 0",
                  Tx_Start, Tx_Data, FIFO_Empty, FIFO_Full, FIFO_Overflow, Count);
      end
      Rst_N = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_latency();
      auto_busy = 1'b1;
      dly_lo = 0; dly_hi = 0; len_lo = 10; len_hi = 10;
      Write_En = 1'b1;
      Tx_Data_In = 8'hA5;
      tick();
      Write_En = 1'b0;
      checks++;
      if (Tx_Start !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: Tx_Start got %b expected 0 at write edge", Tx_Start);
      end
      tick();
      checks++;
      if (Tx_Start !== 1'b1 || Tx_Data !== 8'hA5 || FIFO_Empty !== 1'b1) begin
         errors++;
         $display("FAIL latency_start: got start=%b data=%h empty=%b expected 1 a5 1", Tx_Start, Tx_Data, FIFO_Empty);
      end
      tick();
      checks++;
      if (Tx_Start !== 1'b0) begin
         errors++;
         $display("FAIL latency_pulse: Tx_Start got %b expected 0 one cycle later", Tx_Start);
      end
      drain(100);
   endtask

   task automatic test_overflow_and_clear();
      logic [7:0] vals [4];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      auto_busy = 1'b0;
      Tx_Busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Write_En = 1'b1;
         Tx_Data_In = vals[i];
         tick();
      end
      checks++;
      if (FIFO_Full !== 1'b1 || Count !== 3'd4) begin
         errors++;
         $display("FAIL fill: got full=%b count=%0d expected 1 4", FIFO_Full, Count);
      end
      Tx_Data_In = 8'h55;
      tick();
      checks++;
      if (FIFO_Overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got %b expected 1", FIFO_Overflow);
      end
      Write_En = 1'b0;
      Ovf_Clr = 1'b1;
      tick();
      checks++;
      if (FIFO_Overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clr: got %b expected 0", FIFO_Overflow);
      end
      Write_En = 1'b1;
      Tx_Data_In = 8'h77;
      tick();
      checks++;
      if (FIFO_Overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set_wins: got %b expected 1", FIFO_Overflow);
      end
      Write_En = 1'b0;
      tick();
      Ovf_Clr = 1'b0;
   endtask

   task automatic test_full_write_on_pop();
      auto_busy = 1'b1;
      dly_lo = 0; dly_hi = 2; len_lo = 2; len_hi = 4;
      Tx_Busy = 1'b0;
      Write_En = 1'b1;
      Tx_Data_In = 8'h66;
      tick();
      Write_En = 1'b0;
      checks++;
      if (Tx_Start !== 1'b1 || Count !== 3'd4 || FIFO_Overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_write_pop: got start=%b count=%0d ovf=%b expected 1 4 0", Tx_Start, Count, FIFO_Overflow);
      end
      drain(200);
   endtask

   task automatic test_back_to_back_random();
      int s0;
      int wrote;
      int n;
      s0 = starts;
      wrote = 0;
      n = 0;
      auto_busy = 1'b1;
      dly_lo = 0; dly_hi = 3; len_lo = 1; len_hi = 6;
      while (wrote < 20 && n < 2000) begin
         if ($urandom_range(1, 0) == 1 && q.size() < FIFO_DEPTH) begin
            Write_En = 1'b1;
            Tx_Data_In = 8'($urandom);
            wrote++;
         end else begin
            Write_En = 1'b0;
         end
         tick();
         n++;
      end
      Write_En = 1'b0;
      drain(500);
      checks++;
      if (starts - s0 != 20) begin
         errors++;
         $display("FAIL random_count: got %0d frames expected 20", starts - s0);
      end
   endtask

   task automatic test_bist_and_reset();
      int s0;
      auto_busy = 1'b1;
      dly_lo = 0; dly_hi = 0; len_lo = 5; len_hi = 5;
      BIST_Mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         Write_En = 1'b1;
         Tx_Data_In = 8'($urandom);
         tick();
         checks++;
         if (Tx_Start !== 1'b0) begin
            errors++;
            $display("FAIL bist_start: got %b expected 0", Tx_Start);
         end
      end
      Write_En = 1'b0;
      BIST_Mode = 1'b0;
      tick();
      s0 = starts;
      Write_En = 1'b1; Tx_Data_In = 8'h31; tick();
      Tx_Data_In = 8'h32; tick();
      Write_En = 1'b0;
      wait_starts(s0 + 1, 50);
      BIST_Mode = 1'b1;
      repeat (25) tick();
      checks++;
      if (Count !== 3'd1 || starts != s0 + 1) begin
         errors++;
         $display("FAIL bist_hold: got count=%0d frames=%0d expected 1 1", Count, starts - s0);
      end
      BIST_Mode = 1'b0;
      drain(100);
      s0 = starts;
      Write_En = 1'b1; Tx_Data_In = 8'h41; tick();
      Tx_Data_In = 8'h42; tick();
      Write_En = 1'b0;
      wait_starts(s0 + 1, 50);
      Rst_N = 1'b0;
      #1;
      checks++;
      if ({Tx_Start, Tx_Data, FIFO_Empty, FIFO_Full, FIFO_Overflow, Count} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_midframe: got start=%b data=%h empty=%b full=%b ovf=%b count=%0d expected 0 00 1 0 0 0",
                  Tx_Start, Tx_Data, FIFO_Empty, FIFO_Full, FIFO_Overflow, Count);
      end
      tick();
      Tx_Busy = 1'b0;
      Rst_N = 1'b1;
      s0 = starts;
      repeat (6) tick();
      checks++;
      if (starts != s0 || Count !== 3'd0) begin
         errors++;
         $display("FAIL reset_flush: got frames=%0d count=%0d expected 0 0", starts - s0, Count);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_overflow_and_clear();
      test_full_write_on_pop();
      test_back_to_back_random();
      test_bist_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
